// File: rtl/mips_mc_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and the datapath/memory.
// The controller takes the master modport; the datapath side takes the slave modport.
interface mips_mc_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             mem_re;
  logic             mem_we;
  logic             ir_we;
  logic             pc_we;
  logic             rf_we;
  logic [1:0]       pcsrc_sel;
  logic [1:0]       regdst_sel;
  logic [1:0]       wb_sel;
  logic             alusrc_sel;
  logic [2:0]       alu_op;
  logic             ext_op;
  logic             illegal;
  logic             retire;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_re, mem_we, ir_we, pc_we, rf_we, pcsrc_sel, regdst_sel, wb_sel,
           alusrc_sel, alu_op, ext_op, illegal, retire, retired_cnt
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_re, mem_we, ir_we, pc_we, rf_we, pcsrc_sel, regdst_sel, wb_sel,
           alusrc_sel, alu_op, ext_op, illegal, retire, retired_cnt
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXE/MEM/WB sequencing over a shared datapath,
// stalling on a single memory port, with a retired-instruction counter.
module mips_mc_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  mips_mc_ctrl_if.master bus
);

  localparam int unsigned ST_W = 3;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXE    = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_LUI  = 3'b011;

  localparam logic [1:0] PC_INC   = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_JMP   = 2'b10;
  localparam logic [1:0] PC_RS    = 2'b11;

  localparam logic [1:0] RD_RT    = 2'b00;
  localparam logic [1:0] RD_RD    = 2'b01;
  localparam logic [1:0] RD_RA    = 2'b10;

  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_MEM   = 2'b01;
  localparam logic [1:0] WB_PC4   = 2'b10;

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Instruction classification from the held IR fields.
  logic is_rtype, is_addu, is_subu, is_jr, is_j, is_jal, is_beq;
  logic is_ori, is_lui, is_lw, is_sw, is_legal;

  always_comb begin
    is_rtype = (bus.op == OP_RTYPE);
    is_addu  = is_rtype && (bus.funct == FN_ADDU);
    is_subu  = is_rtype && (bus.funct == FN_SUBU);
    is_jr    = is_rtype && (bus.funct == FN_JR);
    is_j     = (bus.op == OP_J);
    is_jal   = (bus.op == OP_JAL);
    is_beq   = (bus.op == OP_BEQ);
    is_ori   = (bus.op == OP_ORI);
    is_lui   = (bus.op == OP_LUI);
    is_lw    = (bus.op == OP_LW);
    is_sw    = (bus.op == OP_SW);
    is_legal = is_addu | is_subu | is_jr | is_j | is_jal | is_beq |
               is_ori | is_lui | is_lw | is_sw;
  end

  // ALU-side controls, established in EXE and held through MEM and WB.
  logic       exe_alusrc_c;
  logic [2:0] exe_alu_op_c;
  logic       exe_ext_op_c;

  always_comb begin
    exe_alusrc_c = 1'b0;
    exe_alu_op_c = ALU_ADD;
    exe_ext_op_c = 1'b0;
    if (is_subu) begin
      exe_alu_op_c = ALU_SUB;
    end else if (is_ori) begin
      exe_alusrc_c = 1'b1;
      exe_alu_op_c = ALU_OR;
    end else if (is_lui) begin
      exe_alusrc_c = 1'b1;
      exe_alu_op_c = ALU_LUI;
    end else if (is_lw || is_sw) begin
      exe_alusrc_c = 1'b1;
      exe_ext_op_c = 1'b1;
    end else if (is_beq) begin
      exe_alu_op_c = ALU_SUB;
      exe_ext_op_c = 1'b1;
    end
  end

  logic       mem_re_c, mem_we_c, ir_we_c, pc_we_c, rf_we_c;
  logic [1:0] pcsrc_c, regdst_c, wb_sel_c;
  logic       alusrc_c, ext_op_c, illegal_c, retire_c;
  logic [2:0] alu_op_c;

  // Next-state and per-state output decode.
  always_comb begin
    state_d   = state_q;
    mem_re_c  = 1'b0;
    mem_we_c  = 1'b0;
    ir_we_c   = 1'b0;
    pc_we_c   = 1'b0;
    rf_we_c   = 1'b0;
    pcsrc_c   = PC_INC;
    regdst_c  = RD_RT;
    wb_sel_c  = WB_ALU;
    alusrc_c  = 1'b0;
    alu_op_c  = ALU_ADD;
    ext_op_c  = 1'b0;
    illegal_c = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_re_c = 1'b1;
        if (bus.mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          pcsrc_c = PC_INC;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_FETCH;
        if (is_j) begin
          pc_we_c = 1'b1;
          pcsrc_c = PC_JMP;
        end else if (is_jal) begin
          pc_we_c  = 1'b1;
          pcsrc_c  = PC_JMP;
          rf_we_c  = 1'b1;
          regdst_c = RD_RA;
          wb_sel_c = WB_PC4;
        end else if (is_jr) begin
          pc_we_c = 1'b1;
          pcsrc_c = PC_RS;
        end else if (!is_legal) begin
          illegal_c = 1'b1;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        alusrc_c = exe_alusrc_c;
        alu_op_c = exe_alu_op_c;
        ext_op_c = exe_ext_op_c;
        if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_addu || is_subu || is_ori || is_lui) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
          if (is_beq && bus.zero) begin
            pc_we_c = 1'b1;
            pcsrc_c = PC_BR;
          end
        end
      end
      S_MEM: begin
        alusrc_c = exe_alusrc_c;
        alu_op_c = exe_alu_op_c;
        ext_op_c = exe_ext_op_c;
        mem_re_c = is_lw;
        mem_we_c = is_sw;
        if (!(is_lw || is_sw)) begin
          state_d = S_FETCH;
        end else if (bus.mem_ready) begin
          state_d = is_lw ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        alusrc_c = exe_alusrc_c;
        alu_op_c = exe_alu_op_c;
        ext_op_c = exe_ext_op_c;
        rf_we_c  = 1'b1;
        regdst_c = is_rtype ? RD_RD : RD_RT;
        wb_sel_c = is_lw ? WB_MEM : WB_ALU;
        state_d  = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    retire_c = (state_d == S_FETCH) && (state_q != S_FETCH);
    cnt_d    = cnt_q + CNT_W'(retire_c);

    // Reset cycles abandon everything and present an all-zero control word.
    if (rst) begin
      state_d   = S_FETCH;
      cnt_d     = '0;
      mem_re_c  = 1'b0;
      mem_we_c  = 1'b0;
      ir_we_c   = 1'b0;
      pc_we_c   = 1'b0;
      rf_we_c   = 1'b0;
      pcsrc_c   = PC_INC;
      regdst_c  = RD_RT;
      wb_sel_c  = WB_ALU;
      alusrc_c  = 1'b0;
      alu_op_c  = ALU_ADD;
      ext_op_c  = 1'b0;
      illegal_c = 1'b0;
      retire_c  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.mem_re      = mem_re_c;
  assign bus.mem_we      = mem_we_c;
  assign bus.ir_we       = ir_we_c;
  assign bus.pc_we       = pc_we_c;
  assign bus.rf_we       = rf_we_c;
  assign bus.pcsrc_sel   = pcsrc_c;
  assign bus.regdst_sel  = regdst_c;
  assign bus.wb_sel      = wb_sel_c;
  assign bus.alusrc_sel  = alusrc_c;
  assign bus.alu_op      = alu_op_c;
  assign bus.ext_op      = ext_op_c;
  assign bus.illegal     = illegal_c;
  assign bus.retire      = retire_c;
  assign bus.retired_cnt = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: each instruction is expanded into its expected per-cycle
// control trace from the instruction-class rules, then replayed against the DUT.
module tb_mips_mc_ctrl;

  localparam int unsigned CNT_W = 32;

  typedef struct packed {
    logic       mem_re;
    logic       mem_we;
    logic       ir_we;
    logic       pc_we;
    logic       rf_we;
    logic [1:0] pcsrc;
    logic [1:0] regdst;
    logic [1:0] wb;
    logic       alusrc;
    logic [2:0] aluop;
    logic       ext;
    logic       illegal;
    logic       retire;
  } outs_t;

  typedef struct packed {
    outs_t            o;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  localparam int C_ADDU = 0, C_SUBU = 1, C_ORI = 2, C_LUI = 3, C_LW = 4, C_SW = 5;
  localparam int C_BEQ = 6, C_J = 7, C_JAL = 8, C_JR = 9, C_ILL_OP = 10, C_ILL_FN = 11;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mips_mc_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mips_mc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  bit          rdy_q[$];
  bit          zero_q[$];
  logic [5:0]  op_q[$];
  logic [5:0]  fn_q[$];
  obs_t        exp_q[$];
  obs_t        got_q[$];
  int unsigned mcnt;
  logic [5:0]  cur_op, cur_fn;

  function automatic void clear_q();
    rdy_q.delete(); zero_q.delete(); op_q.delete(); fn_q.delete();
    exp_q.delete(); got_q.delete();
  endfunction

  function automatic void push(bit rdy, bit z, outs_t o);
    obs_t e;
    e.o   = o;
    e.cnt = CNT_W'(mcnt);
    exp_q.push_back(e);
    rdy_q.push_back(rdy);
    zero_q.push_back(z);
    op_q.push_back(cur_op);
    fn_q.push_back(cur_fn);
    if (o.retire) mcnt++;
  endfunction

  // Pick IR fields for a class; don't-care fields are randomised.
  function automatic void set_instr(int cls);
    logic [5:0] r;
    cur_fn = 6'($urandom);
    case (cls)
      C_ADDU: begin cur_op = 6'h00; cur_fn = 6'b100001; end
      C_SUBU: begin cur_op = 6'h00; cur_fn = 6'b100011; end
      C_JR:   begin cur_op = 6'h00; cur_fn = 6'b001000; end
      C_ORI:  cur_op = 6'b001101;
      C_LUI:  cur_op = 6'b001111;
      C_LW:   cur_op = 6'b100011;
      C_SW:   cur_op = 6'b101011;
      C_BEQ:  cur_op = 6'b000100;
      C_J:    cur_op = 6'b000010;
      C_JAL:  cur_op = 6'b000011;
      C_ILL_OP: begin
        do r = 6'($urandom);
        while (r inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h0d, 6'h0f, 6'h23, 6'h2b});
        cur_op = r;
      end
      default: begin
        cur_op = 6'h00;
        do r = 6'($urandom);
        while (r inside {6'b100001, 6'b100011, 6'b001000});
        cur_fn = r;
      end
    endcase
  endfunction

  // Expected trace of one instruction from its class, stall counts and zero flag.
  function automatic void build(int cls, int fs, int ms, bit z);
    outs_t o, ctl;
    bit    mem_op, rtype;
    set_instr(cls);
    for (int k = 0; k < fs; k++) begin
      o = '0; o.mem_re = 1'b1;
      push(1'b0, 1'($urandom), o);
    end
    o = '0; o.mem_re = 1'b1; o.ir_we = 1'b1; o.pc_we = 1'b1;
    push(1'b1, 1'($urandom), o);

    o = '0;
    case (cls)
      C_J:   begin o.pc_we = 1; o.pcsrc = 2'd2; o.retire = 1; end
      C_JAL: begin o.pc_we = 1; o.pcsrc = 2'd2; o.rf_we = 1; o.regdst = 2'd2; o.wb = 2'd2; o.retire = 1; end
      C_JR:  begin o.pc_we = 1; o.pcsrc = 2'd3; o.retire = 1; end
      C_ILL_OP, C_ILL_FN: begin o.illegal = 1; o.retire = 1; end
      default: ;
    endcase
    push(1'($urandom), 1'($urandom), o);
    if (o.retire) return;

    ctl = '0;
    case (cls)
      C_SUBU: ctl.aluop = 3'd1;
      C_ORI:  begin ctl.alusrc = 1; ctl.aluop = 3'd2; end
      C_LUI:  begin ctl.alusrc = 1; ctl.aluop = 3'd3; end
      C_LW, C_SW: begin ctl.alusrc = 1; ctl.ext = 1; end
      C_BEQ:  begin ctl.aluop = 3'd1; ctl.ext = 1; end
      default: ;
    endcase

    o = ctl;
    if (cls == C_BEQ) begin
      if (z) begin o.pc_we = 1; o.pcsrc = 2'd1; end
      o.retire = 1;
      push(1'($urandom), z, o);
      return;
    end
    push(1'($urandom), 1'($urandom), o);

    mem_op = (cls == C_LW) || (cls == C_SW);
    if (mem_op) begin
      for (int k = 0; k <= ms; k++) begin
        o = ctl;
        o.mem_re = (cls == C_LW);
        o.mem_we = (cls == C_SW);
        o.retire = (k == ms) && (cls == C_SW);
        push(k == ms, 1'($urandom), o);
      end
      if (cls == C_SW) return;
    end

    rtype = (cls == C_ADDU) || (cls == C_SUBU);
    o = ctl;
    o.rf_we  = 1;
    o.regdst = rtype ? 2'd1 : 2'd0;
    o.wb     = (cls == C_LW) ? 2'd1 : 2'd0;
    o.retire = 1;
    push(1'($urandom), 1'($urandom), o);
  endfunction

  function automatic obs_t sample();
    obs_t s;
    s.o.mem_re  = bus.mem_re;
    s.o.mem_we  = bus.mem_we;
    s.o.ir_we   = bus.ir_we;
    s.o.pc_we   = bus.pc_we;
    s.o.rf_we   = bus.rf_we;
    s.o.pcsrc   = bus.pcsrc_sel;
    s.o.regdst  = bus.regdst_sel;
    s.o.wb      = bus.wb_sel;
    s.o.alusrc  = bus.alusrc_sel;
    s.o.aluop   = bus.alu_op;
    s.o.ext     = bus.ext_op;
    s.o.illegal = bus.illegal;
    s.o.retire  = bus.retire;
    s.cnt       = bus.retired_cnt;
    return s;
  endfunction

  // Replay the queued stimulus one cycle at a time, capturing outputs mid-cycle.
  task automatic run();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      bus.mem_ready = rdy_q[i];
      bus.zero      = zero_q[i];
      bus.op        = op_q[i];
      bus.funct     = fn_q[i];
      #1;
      got_q.push_back(sample());
    end
  endtask

  task automatic test_reset();
    obs_t s;
    rst = 1'b1;
    mcnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.mem_ready = 1'($urandom);
      bus.zero      = 1'($urandom);
      bus.op        = 6'($urandom);
      bus.funct     = 6'($urandom);
      #1;
      s = sample();
      checks++;
      if (s !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got %h want 0", i, s);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    checks++;
    if (bus.mem_re !== 1'b1 || bus.retired_cnt !== '0) begin
      errors++;
      $display("FAIL reset_release mem_re %b cnt %0d want 1 0", bus.mem_re, bus.retired_cnt);
    end
  endtask

  task automatic test_addu();
    clear_q();
    build(C_ADDU, 0, 0, 1'b0);
    run();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL addu cycle %0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_lw_stall();
    clear_q();
    build(C_LW, 0, 3, 1'b0);
    run();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL lw_stall cycle %0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_beq();
    clear_q();
    build(C_BEQ, 1, 0, 1'b1);
    build(C_BEQ, 0, 0, 1'b0);
    run();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL beq cycle %0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_jumps();
    clear_q();
    build(C_JAL, 0, 0, 1'b0);
    build(C_J, 2, 0, 1'b0);
    build(C_JR, 0, 0, 1'b0);
    run();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL jumps cycle %0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_illegal();
    clear_q();
    set_instr(C_ILL_OP);
    build(C_ILL_OP, 0, 0, 1'b0);
    exp_q.delete();
    rdy_q.delete(); zero_q.delete(); op_q.delete(); fn_q.delete();
    mcnt = mcnt - 1;
    cur_op = 6'b111111;
    begin
      outs_t o;
      o = '0; o.mem_re = 1; o.ir_we = 1; o.pc_we = 1;
      push(1'b1, 1'b0, o);
      o = '0; o.illegal = 1; o.retire = 1;
      push(1'b1, 1'b1, o);
    end
    build(C_ILL_FN, 1, 0, 1'b0);
    run();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL illegal cycle %0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    build(C_SW, 0, 3, 1'b0);
    while (exp_q.size() > 4) begin
      void'(exp_q.pop_back()); void'(rdy_q.pop_back()); void'(zero_q.pop_back());
      void'(op_q.pop_back());  void'(fn_q.pop_back());
    end
    run();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_mid_pre cycle %0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b1;
      bus.mem_ready = 1'b0;
      #1;
      checks++;
      if (bus.mem_we !== 1'b0 || sample() !== '0) begin
        errors++;
        $display("FAIL reset_mid_abort cycle %0d mem_we %b got %h want 0", i, bus.mem_we, sample());
      end
    end
    @(negedge clk);
    rst = 1'b0;
    mcnt = 0;
    #1;
    checks++;
    if (bus.mem_re !== 1'b1 || bus.mem_we !== 1'b0 || bus.retired_cnt !== '0) begin
      errors++;
      $display("FAIL reset_mid_fetch mem_re %b mem_we %b cnt %0d want 1 0 0",
               bus.mem_re, bus.mem_we, bus.retired_cnt);
    end
  endtask

  task automatic test_random();
    clear_q();
    for (int n = 0; n < 40; n++) begin
      build($urandom_range(0, 11), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end
    run();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random cycle %0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;
    bus.op        = '0;
    bus.funct     = '0;
    cur_op        = '0;
    cur_fn        = '0;
    mcnt          = 0;
    @(posedge clk);
    test_reset();
    test_addu();
    test_lw_stall();
    test_beq();
    test_jumps();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
